// File: rtl/id_digit_sequencer_if.sv
// Handshake and result bundle between the digit sequencer and its user / ALU stage.
// The sequencer is the slave side; the bench or the surrounding datapath is the master.
interface id_digit_sequencer_if;
    logic        start;
    logic        step_en;
    logic [7:0]  a_in;
    logic [3:0]  ans;
    logic [7:0]  a_out;
    logic [15:0] opdec;
    logic [3:0]  student_id;
    logic        busy;
    logic        done;
    logic [8:0]  match_mask;
    logic [3:0]  match_count;
    logic        any_match;

    modport slave (
        input  start, step_en, a_in, ans,
        output a_out, opdec, student_id, busy, done, match_mask, match_count, any_match
    );

    modport master (
        output start, step_en, a_in, ans,
        input  a_out, opdec, student_id, busy, done, match_mask, match_count, any_match
    );
endinterface

// File: rtl/id_digit_sequencer.sv
// Walks the nine student-ID digit slots, driving a one-hot opcode and digit to a
// combinational compare ALU and accumulating its per-slot match answers.
module id_digit_sequencer #(
    parameter logic [35:0] STUDENT_ID = 36'h876543210,
    parameter int          NUM_DIGITS = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    id_digit_sequencer_if.slave bus
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [3:0]  next_idx;
    logic [7:0]  a_reg;
    logic [15:0] opdec_reg;
    logic [3:0]  digit_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [8:0]  mask_reg;
    logic [3:0]  count_reg;
    logic        unused_ans;

    function automatic logic [3:0] digit_of(input logic [3:0] k);
        return STUDENT_ID[{k, 2'b00} +: 4];
    endfunction

    function automatic logic [15:0] onehot_of(input logic [3:0] k);
        return 16'h0001 << k;
    endfunction

    assign next_idx   = idx + 4'd1;
    assign unused_ans = ^bus.ans[3:1];

    // Opcode and digit are loaded one edge ahead so they are stable for the whole slot cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= 4'd0;
            a_reg     <= 8'h00;
            opdec_reg <= 16'h0000;
            digit_reg <= 4'h0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            mask_reg  <= 9'h000;
            count_reg <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    opdec_reg <= 16'h0000;
                    digit_reg <= 4'h0;
                    if (bus.start) begin
                        a_reg     <= bus.a_in;
                        mask_reg  <= 9'h000;
                        count_reg <= 4'd0;
                        idx       <= 4'd0;
                        opdec_reg <= onehot_of(4'd0);
                        digit_reg <= digit_of(4'd0);
                        busy_reg  <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.step_en) begin
                        mask_reg[idx] <= bus.ans[0];
                        count_reg     <= count_reg + {3'b000, bus.ans[0]};
                        if (idx == LAST_IDX) begin
                            opdec_reg <= 16'h0000;
                            digit_reg <= 4'h0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx       <= next_idx;
                            opdec_reg <= onehot_of(next_idx);
                            digit_reg <= digit_of(next_idx);
                        end
                    end
                end
                DONE: begin
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_out       = a_reg;
    assign bus.opdec       = opdec_reg;
    assign bus.student_id  = digit_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.match_mask  = mask_reg;
    assign bus.match_count = count_reg;
    assign bus.any_match   = |mask_reg;

endmodule

// File: tb/tb_id_digit_sequencer.sv
// Self-checking bench for id_digit_sequencer: directed scans plus randomized operands
// and step_en patterns, compared against a slot-by-slot behavioural model.
module tb_id_digit_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  ans_hi = 3'b000;
    logic [35:0] id_value = 36'h876543210;
    int          errors = 0;
    int          checks = 0;

    id_digit_sequencer_if bus();

    id_digit_sequencer dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: a match when either operand nibble equals the presented digit.
    assign bus.ans = {ans_hi, (bus.a_out[3:0] == bus.student_id) || (bus.a_out[7:4] == bus.student_id)};

    function automatic logic [8:0] model_mask(input logic [7:0] a);
        logic [8:0] m;
        logic [3:0] d;
        m = 9'h000;
        for (int k = 0; k < 9; k++) begin
            d = id_value[4*k +: 4];
            m[k] = (a[3:0] == d) || (a[7:4] == d);
        end
        return m;
    endfunction

    function automatic logic [3:0] popcount9(input logic [8:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < 9; k++) c = c + 4'(m[k]);
        return c;
    endfunction

    task automatic test_reset();
        bus.start = 1'b0; bus.step_en = 1'b0; bus.a_in = 8'h00;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.opdec, bus.student_id, bus.a_out} !== 30'h0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got busy=%b done=%b opdec=%h sid=%h a_out=%h exp all zero",
                     bus.busy, bus.done, bus.opdec, bus.student_id, bus.a_out);
        end
        checks++;
        if ({bus.match_mask, bus.match_count, bus.any_match} !== 14'h0) begin
            errors++;
            $display("[TB] FAIL reset_results got mask=%h count=%0d any=%b exp all zero",
                     bus.match_mask, bus.match_count, bus.any_match);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One complete scan checked cycle by cycle; the model tracks only the current slot.
    task automatic run_scan(input logic [7:0] a, input int stall_slot, input int stall_len,
                            input bit random_step, input int restart_cyc, input string tag);
        int         slot, cyc, stalls, stall_left;
        bit         fin, exp_done, step;
        logic [8:0] em, partial;
        em = model_mask(a);
        slot = 0; cyc = 1; stalls = 0; stall_left = stall_len; fin = 0; exp_done = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = a; bus.step_en = 1'b1; ans_hi = 3'($urandom);
        @(negedge clk);
        bus.start = 1'b0; bus.a_in = 8'($urandom);
        while (!fin && cyc < 64) begin
            partial = em & ((9'h001 << slot) - 9'h001);
            if (exp_done) begin
                checks++;
                if ({bus.done, bus.busy, bus.opdec, bus.student_id} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
                    errors++;
                    $display("[TB] FAIL %s done_state cyc=%0d got done=%b busy=%b opdec=%h sid=%h exp 1 0 0000 0",
                             tag, cyc, bus.done, bus.busy, bus.opdec, bus.student_id);
                end
                checks++;
                if (cyc !== 10 + stalls) begin
                    errors++;
                    $display("[TB] FAIL %s done_latency got cyc=%0d exp %0d", tag, cyc, 10 + stalls);
                end
                checks++;
                if ({bus.match_mask, bus.match_count, bus.any_match} !== {em, popcount9(em), |em}) begin
                    errors++;
                    $display("[TB] FAIL %s results got mask=%h count=%0d any=%b exp mask=%h count=%0d any=%b",
                             tag, bus.match_mask, bus.match_count, bus.any_match, em, popcount9(em), |em);
                end
                bus.start = 1'b0;
                fin = 1;
            end else begin
                checks++;
                if ({bus.busy, bus.done, bus.opdec, bus.student_id} !==
                    {1'b1, 1'b0, 16'h0001 << slot, id_value[4*slot +: 4]}) begin
                    errors++;
                    $display("[TB] FAIL %s scan_ctrl cyc=%0d slot=%0d got busy=%b done=%b opdec=%h sid=%h exp 1 0 %h %h",
                             tag, cyc, slot, bus.busy, bus.done, bus.opdec, bus.student_id,
                             16'h0001 << slot, id_value[4*slot +: 4]);
                end
                checks++;
                if ({bus.a_out, bus.match_mask, bus.match_count} !== {a, partial, popcount9(partial)}) begin
                    errors++;
                    $display("[TB] FAIL %s scan_data cyc=%0d got a_out=%h mask=%h count=%0d exp %h %h %0d",
                             tag, cyc, bus.a_out, bus.match_mask, bus.match_count, a, partial, popcount9(partial));
                end
                if (slot == stall_slot && stall_left > 0) begin
                    step = 0; stall_left--;
                end else if (random_step) begin
                    step = ($urandom_range(0, 3) != 0);
                end else begin
                    step = 1;
                end
                bus.step_en = step;
                if (!step) stalls++;
                else if (slot == 8) exp_done = 1;
                else slot++;
                if (cyc == restart_cyc) begin
                    bus.start = 1'b1; bus.a_in = 8'h00;
                end else begin
                    bus.start = 1'b0;
                end
            end
            ans_hi = 3'($urandom);
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("[TB] FAIL %s timeout got no completion within %0d cycles exp done", tag, cyc);
        end
        checks++;
        if ({bus.done, bus.busy, bus.opdec, bus.a_out, bus.match_mask} !== {1'b0, 1'b0, 16'h0, a, em}) begin
            errors++;
            $display("[TB] FAIL %s idle_after got done=%b busy=%b opdec=%h a_out=%h mask=%h exp 0 0 0000 %h %h",
                     tag, bus.done, bus.busy, bus.opdec, bus.a_out, bus.match_mask, a, em);
        end
    endtask

    task automatic test_basic_scans();
        run_scan(8'h37, -1, 0, 0, -1, "scan_37");
        run_scan(8'h99, -1, 0, 0, -1, "scan_99");
        run_scan(8'h44, -1, 0, 0, -1, "scan_44");
    endtask

    task automatic test_stall();
        run_scan(8'h37, 4, 3, 0, -1, "stall_slot4");
        run_scan(8'h58, 8, 2, 0, -1, "stall_slot8");
    endtask

    task automatic test_start_ignored();
        run_scan(8'h37, -1, 0, 0, 5, "restart_ignored");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = 8'h37; bus.step_en = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.opdec, bus.student_id, bus.a_out,
             bus.match_mask, bus.match_count, bus.any_match} !== 44'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset got busy=%b done=%b opdec=%h sid=%h a_out=%h mask=%h count=%0d any=%b exp all zero",
                     bus.busy, bus.done, bus.opdec, bus.student_id, bus.a_out,
                     bus.match_mask, bus.match_count, bus.any_match);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.done, bus.busy} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL mid_reset_hold got done=%b busy=%b exp 0 0", bus.done, bus.busy);
            end
        end
        reset_n = 1'b1;
        run_scan(8'h37, -1, 0, 0, -1, "after_reset");
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] a;
        for (int n = 0; n < 12; n++) begin
            a[3:0] = 4'($urandom_range(0, 15));
            a[7:4] = 4'($urandom_range(0, 9));
            run_scan(a, int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), 1, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic_scans();
        test_stall();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got simulation still running exp finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/id_digit_sequencer.md
Name: id_digit_sequencer

Overview:
- Upstream sequencer for the student-ID compare ALU stage.
- On `start`, latches an 8-bit operand and drives one one-hot opcode per digit slot, 9 slots in total, together with the matching student-ID digit.
- Samples the ALU's match answer for every slot and accumulates a 9-bit match mask and a match count.
- Signals completion with a one-cycle `done` pulse. The ALU stage is combinational, so its answer is valid in the same cycle as the driven opcode and digit.

Parameters:
- STUDENT_ID, 36'h876543210, nine packed 4-bit digits; digit k = STUDENT_ID[4k+3:4k], k=0..8.
- NUM_DIGITS, 9, number of digit slots scanned; fixed at 9; opcode width stays 16.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; sampled in IDLE only.
- step_en  in  1  advance enable; the scan holds its slot while 0.
- a_in  in  8  operand captured when start is accepted.
- ans  in  4  ALU answer; only ans[0] is used (1 = match); ans[3:1] ignored.
- a_out  out  8  latched operand to the ALU A input; stable for the whole scan.
- opdec  out  16  one-hot opcode to the ALU; bit idx set during SCAN, else 16'h0000.
- student_id  out  4  digit idx of STUDENT_ID during SCAN, else 4'h0.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse in DONE.
- match_mask  out  9  bit k = 1 if slot k matched.
- match_count  out  4  number of matched slots, 0..9.
- any_match  out  1  OR of match_mask.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE, idx=0.
  - a_out=0, opdec=0, student_id=0, busy=0, done=0, match_mask=0, match_count=0, any_match=0.
- State IDLE:
  - opdec=0, student_id=0.
  - If start=1 at an edge: a_out<=a_in, match_mask<=0, match_count<=0, idx<=0, go to SCAN.
  - The previous results stay visible until that edge.
- State SCAN:
  - opdec and student_id are registered and reflect the current idx throughout the cycle: opdec has bit idx set, student_id = STUDENT_ID[4*idx+3:4*idx].
  - At each edge with step_en=1:
    - match_mask[idx]<=ans[0].
    - match_count<=match_count+ans[0].
    - If idx==8, go to DONE; otherwise idx<=idx+1.
  - At an edge with step_en=0: no state, idx or result change; opdec and student_id hold.
- State DONE:
  - done=1, busy=0, opdec=0, student_id=0.
  - Unconditionally return to IDLE on the next edge.
- Latency: with step_en held 1, start accepted at edge 0 → SCAN cycles 1..9 → done high in cycle 10 → IDLE in cycle 11.
- start in SCAN or DONE is ignored; there is no queueing.
- start and step_en both high in IDLE: step_en is irrelevant in IDLE; the scan begins at slot 0 next cycle.
- Slot 8 sampled with step_en=0 holds slot 8; DONE is reached only when step_en=1 at slot 8.
- match_count never exceeds 9; 4 bits is sufficient, no wrap.
- any_match is combinational from match_mask.
- Reset mid-scan aborts immediately to the reset values; there is no done pulse.
- opdec is one-hot during SCAN and exactly zero otherwise; it never carries more than one set bit.

Test Plan:
- Default STUDENT_ID, behavioural ALU model (ans[0] = A[3:0]==id || A[7:4]==id), a_in=8'h37, step_en=1 → opdec walks 16'h0001..16'h0100, student_id 0..8; done in cycle 10; match_mask=9'h088, match_count=3'd2, any_match=1.
- a_in=8'h99 → match_mask=9'h000, match_count=0, any_match=0, done pulses exactly once.
- a_in=8'h44 → match_mask=9'h010, match_count=1.
- a_in=8'h37, step_en low for 3 cycles while at slot 4 → opdec stays 16'h0010 and student_id 4'h4 for those cycles; done arrives 3 cycles late; results identical to the first test.
- start pulsed again in cycle 5 of a scan, with a_in changed to 8'h00 → ignored; a_out stays 8'h37 and results equal the first test.
- reset_n low in cycle 6 of a scan → all outputs zero asynchronously, no done pulse; a new start after release runs a clean full scan.
